uart_tick_gen: RTL and testbench

Parametrised, lock-qualified baud-tick generator for the UART clock domain. It runs on the PLL-derived UART clock and produces per-channel single-cycle enables: rx_tick at baud×OVERSAMPLE and tx_tick at baud. Each channel uses a fractional phase accumulator whose increment is programmable at runtime. Ticks are suppressed until the PLL `locked` flag has been stable for a programmable time.

---
 rtl/uart_clock_pkg.sv | 38 +++
 rtl/uart_tick_channel.sv | 75 +++++++
 rtl/uart_tick_gen.sv | 125 ++++++++++++
 tb/tb_uart_tick_gen.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_clock_pkg.sv
// ============================================================================
// Module      : uart_clock_pkg
// Description : Shared types and elaboration-time helpers for the UART tick
//               generator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_clock_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    RUN       = 2'd2
  } lock_state_t;

  // Width of a channel index; a single channel still needs a 1-bit select.
  function automatic int calc_ch_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  // round(baud * oversample * 2^acc_w / clk_hz), masked to acc_w bits.
  function automatic logic [63:0] calc_inc(
    input logic [63:0] clk_hz,
    input logic [63:0] baud,
    input logic [63:0] oversample,
    input int          acc_w
  );
    logic [63:0] num;
    logic [63:0] quo;
    num = (baud * oversample) << acc_w;
    quo = (num + (clk_hz >> 1)) / clk_hz;
    return quo & ((64'd1 << acc_w) - 64'd1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tick_channel.sv
// ============================================================================
// Module      : uart_tick_channel
// Description : One channel: programmable phase increment, fractional phase
//               accumulator, oversample counter and registered tick outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tick_channel #(
  parameter int               ACC_W       = 24,
  parameter int               OVERSAMPLE  = 16,
  parameter logic [ACC_W-1:0] DEFAULT_INC = '0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_active,
  input  logic             i_inc_we,
  input  logic [ACC_W-1:0] i_inc_wdata,
  output logic             o_rx_tick,
  output logic             o_tx_tick
);

  localparam int              c_ov_w    = $clog2(OVERSAMPLE);
  localparam logic [c_ov_w-1:0] c_ov_last = c_ov_w'(OVERSAMPLE - 1);

  logic [ACC_W-1:0]  r_inc;
  logic [ACC_W-1:0]  r_acc;
  logic [c_ov_w-1:0] r_ov;
  logic              r_rx_tick;
  logic              r_tx_tick;

  logic [ACC_W:0]    w_sum;
  logic              w_carry;
  logic              w_ov_last;

  assign w_sum     = {1'b0, r_acc} + {1'b0, r_inc};
  assign w_carry   = w_sum[ACC_W];
  assign w_ov_last = (r_ov == c_ov_last);

  // The increment register is independent of activity so that rate settings
  // survive lock loss; acc/ov are kept across increment writes for glitch-free
  // rate changes.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_inc     <= DEFAULT_INC;
      r_acc     <= '0;
      r_ov      <= '0;
      r_rx_tick <= 1'b0;
      r_tx_tick <= 1'b0;
    end else begin
      if (i_inc_we) begin
        r_inc <= i_inc_wdata;
      end
      if (i_active) begin
        r_acc     <= w_sum[ACC_W-1:0];
        r_rx_tick <= w_carry;
        r_tx_tick <= w_carry & w_ov_last;
        if (w_carry) begin
          r_ov <= w_ov_last ? '0 : r_ov + 1'b1;
        end
      end else begin
        r_acc     <= '0;
        r_ov      <= '0;
        r_rx_tick <= 1'b0;
        r_tx_tick <= 1'b0;
      end
    end
  end

  assign o_rx_tick = r_rx_tick;
  assign o_tx_tick = r_tx_tick;

endmodule

`default_nettype wire

// File: rtl/uart_tick_gen.sv
// ============================================================================
// Module      : uart_tick_gen
// Description : Lock-qualified multi-channel UART baud-tick generator with
//               runtime-programmable fractional increments.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tick_gen
  import uart_clock_pkg::*;
#(
  parameter int CLK_HZ       = 100500000,
  parameter int NUM_CH       = 2,
  parameter int ACC_W        = 24,
  parameter int OVERSAMPLE   = 16,
  parameter int DEFAULT_BAUD = 115200,
  parameter int LOCK_STABLE  = 1024,
  localparam int CH_W        = calc_ch_w(NUM_CH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              locked,
  output logic              ready,
  input  logic [NUM_CH-1:0] ch_enable,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [ACC_W-1:0]  cfg_inc,
  output logic [NUM_CH-1:0] rx_tick,
  output logic [NUM_CH-1:0] tx_tick
);

  localparam logic [ACC_W-1:0] c_default_inc =
    ACC_W'(calc_inc(64'(CLK_HZ), 64'(DEFAULT_BAUD), 64'(OVERSAMPLE), ACC_W));
  localparam int                c_cnt_w       = $clog2(LOCK_STABLE + 1);
  localparam logic [c_cnt_w-1:0] c_lock_stable = c_cnt_w'(LOCK_STABLE);

  lock_state_t        r_state;
  lock_state_t        w_state_next;
  logic [c_cnt_w-1:0] r_cnt;
  logic [c_cnt_w-1:0] w_cnt_next;
  logic               r_ready;
  logic               r_cfg_ready;
  logic               w_cfg_fire;

  // ---------------------------------------------------------------------------
  // Lock qualification
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= WAIT_LOCK;
      r_cnt       <= '0;
      r_ready     <= 1'b0;
      r_cfg_ready <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_ready     <= (w_state_next == RUN);
      r_cfg_ready <= 1'b1;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    if (!locked) begin
      w_state_next = WAIT_LOCK;
      w_cnt_next   = '0;
    end else begin
      case (r_state)
        WAIT_LOCK: begin
          w_state_next = STABLE;
          w_cnt_next   = c_cnt_w'(1);
        end
        STABLE: begin
          if (r_cnt >= c_lock_stable) begin
            w_state_next = RUN;
          end else begin
            w_cnt_next = r_cnt + 1'b1;
          end
        end
        RUN: begin
          w_state_next = RUN;
        end
        default: begin
          w_state_next = WAIT_LOCK;
          w_cnt_next   = '0;
        end
      endcase
    end
  end

  assign ready     = r_ready;
  assign cfg_ready = r_cfg_ready;
  assign w_cfg_fire = cfg_valid & r_cfg_ready;

  // ---------------------------------------------------------------------------
  // Channels. Gating on the live locked level drops a carry that coincides
  // with lock loss, one edge before ready itself falls.
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic w_active;
    logic w_inc_we;

    assign w_active = r_ready & locked & ch_enable[gi];
    assign w_inc_we = w_cfg_fire & (cfg_ch == CH_W'(gi));

    uart_tick_channel #(
      .ACC_W      (ACC_W),
      .OVERSAMPLE (OVERSAMPLE),
      .DEFAULT_INC(c_default_inc)
    ) u_channel (
      .i_clk      (clock),
      .i_rst      (reset),
      .i_active   (w_active),
      .i_inc_we   (w_inc_we),
      .i_inc_wdata(cfg_inc),
      .o_rx_tick  (rx_tick[gi]),
      .o_tx_tick  (tx_tick[gi])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_tick_gen.sv
// ============================================================================
// Module      : tb_uart_tick_gen
// Description : Self-checking bench for uart_tick_gen (small-parameter and
//               default-parameter instances).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tick_gen;

  localparam int    c_os  = 4;
  localparam int    c_ls  = 8;
  localparam longint c_small_def_inc = (longint'(115200) * 4 * 256 + 100500000 / 2) / 100500000;
  localparam longint c_big_def_inc   = 307699;

  logic       clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset, locked, cfg_valid, ready, cfg_ready;
  logic [2:0] ch_enable, rx_tick, tx_tick;
  logic [1:0] cfg_ch;
  logic [7:0] cfg_inc;

  logic        d_reset, d_locked, d_ready, d_cfg_ready, d_cfg_valid;
  logic [1:0]  d_en, d_rx, d_tx;
  logic [0:0]  d_cfg_ch;
  logic [23:0] d_cfg_inc;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural reference: unbounded phase, run-length lock qualification.
  int         m_run;
  bit         m_ready, m_cfg_ready;
  longint     m_phase [3];
  int         m_cnt   [3];
  logic [7:0] m_inc   [3];
  logic [2:0] m_rx, m_tx;

  uart_tick_gen #(
    .CLK_HZ(100500000), .NUM_CH(3), .ACC_W(8), .OVERSAMPLE(c_os),
    .DEFAULT_BAUD(115200), .LOCK_STABLE(c_ls)
  ) dut (
    .clock(clock), .reset(reset), .locked(locked), .ready(ready),
    .ch_enable(ch_enable), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_inc(cfg_inc), .rx_tick(rx_tick), .tx_tick(tx_tick)
  );

  uart_tick_gen dut_def (
    .clock(clock), .reset(d_reset), .locked(d_locked), .ready(d_ready),
    .ch_enable(d_en), .cfg_valid(d_cfg_valid), .cfg_ready(d_cfg_ready),
    .cfg_ch(d_cfg_ch), .cfg_inc(d_cfg_inc), .rx_tick(d_rx), .tx_tick(d_tx)
  );

  task automatic step();
    @(posedge clock);
    if (reset) begin
      m_run = 0; m_ready = 0; m_cfg_ready = 0; m_rx = '0; m_tx = '0;
      for (int i = 0; i < 3; i++) begin
        m_phase[i] = 0; m_cnt[i] = 0; m_inc[i] = 8'(c_small_def_inc);
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (m_ready && locked && ch_enable[i]) begin
          longint old;
          old = m_phase[i];
          m_phase[i] = m_phase[i] + longint'(m_inc[i]);
          m_rx[i] = (m_phase[i] / 256) != (old / 256);
          if (m_rx[i]) m_cnt[i]++;
          m_tx[i] = m_rx[i] && (m_cnt[i] % c_os == 0);
        end else begin
          m_phase[i] = 0; m_cnt[i] = 0; m_rx[i] = 1'b0; m_tx[i] = 1'b0;
        end
      end
      if (cfg_valid && m_cfg_ready && cfg_ch < 2'd3) m_inc[cfg_ch] = cfg_inc;
      m_run = locked ? m_run + 1 : 0;
      m_ready = (m_run > c_ls);
      m_cfg_ready = 1'b1;
    end
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b1; locked = 1'b0; ch_enable = '0; cfg_valid = 1'b0;
    repeat (2) step();
    reset = 1'b0;
  endtask

  task automatic cfg_write(input logic [1:0] ch, input logic [7:0] inc);
    cfg_valid = 1'b1; cfg_ch = ch; cfg_inc = inc;
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic wait_ready(input int budget, output bit ok, output int steps);
    ok = 1'b0; steps = 0;
    for (int k = 0; k < budget; k++) begin
      step();
      steps++;
      if (ready === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; locked = 1'b1; ch_enable = 3'b111;
    for (int k = 0; k < 3; k++) begin
      cfg_valid = 1'b1; cfg_ch = 2'($urandom_range(0, 3)); cfg_inc = 8'($urandom_range(0, 255));
      step();
      n_tests++;
      if ({ready, cfg_ready, rx_tick, tx_tick} !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_outputs: got %b want 00000000", {ready, cfg_ready, rx_tick, tx_tick});
      end
    end
    reset = 1'b0; cfg_valid = 1'b0; locked = 1'b0;
    step();
    n_tests++;
    if ({ready, cfg_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL reset_release: got ready,cfg_ready=%b want 01", {ready, cfg_ready});
    end
  endtask

  task automatic test_lock_qual();
    do_reset();
    locked = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      n_tests++;
      if (ready !== 1'(k > c_ls)) begin
        n_fail++;
        $display("FAIL lock_qual_k%0d: got ready=%b want %b", k, ready, k > c_ls);
      end
    end
    do_reset();
    locked = 1'b1;
    repeat (3) step();
    locked = 1'b0;
    step();
    locked = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      n_tests++;
      if (ready !== 1'(k > c_ls)) begin
        n_fail++;
        $display("FAIL lock_restart_k%0d: got ready=%b want %b", k, ready, k > c_ls);
      end
    end
  endtask

  task automatic test_tick_rate();
    bit ok; int st;
    logic [2:0] e_rx, e_tx;
    do_reset();
    locked = 1'b1; ch_enable = 3'b001;
    step();
    cfg_write(2'd0, 8'd64);
    wait_ready(40, ok, st);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL tick_rate_ready: got ready=0 after 40 cycles want 1"); end
    for (int n = 1; n <= 64; n++) begin
      step();
      e_rx = {2'b00, 1'(n % 4 == 0)};
      e_tx = {2'b00, 1'(n % 16 == 0)};
      n_tests++;
      if ({rx_tick, tx_tick} !== {e_rx, e_tx}) begin
        n_fail++;
        $display("FAIL tick_rate_n%0d: got rx,tx=%b,%b want %b,%b", n, rx_tick, tx_tick, e_rx, e_tx);
      end
    end
  endtask

  task automatic test_fractional();
    bit ok; int st; int cnt; int t, tp;
    logic [2:0] e_rx, e_tx;
    do_reset();
    locked = 1'b1; ch_enable = 3'b010;
    step();
    cfg_write(2'd1, 8'd96);
    wait_ready(40, ok, st);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL frac_ready: got ready=0 after 40 cycles want 1"); end
    cnt = 0;
    for (int n = 1; n <= 240; n++) begin
      step();
      t = (3 * n) / 8; tp = (3 * (n - 1)) / 8;
      e_rx = {1'b0, 1'(t != tp), 1'b0};
      e_tx = {1'b0, 1'(t != tp && t % c_os == 0), 1'b0};
      if (rx_tick[1] === 1'b1) cnt++;
      n_tests++;
      if ({rx_tick, tx_tick} !== {e_rx, e_tx}) begin
        n_fail++;
        $display("FAIL frac_n%0d: got rx,tx=%b,%b want %b,%b", n, rx_tick, tx_tick, e_rx, e_tx);
      end
    end
    n_tests++;
    if (cnt != 90) begin n_fail++; $display("FAIL frac_count: got %0d ticks want 90", cnt); end
  endtask

  task automatic test_live_reconfig();
    bit ok; int st;
    logic e_rx, e_tx;
    do_reset();
    locked = 1'b1; ch_enable = 3'b001;
    step();
    cfg_write(2'd0, 8'd64);
    wait_ready(40, ok, st);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL reconfig_ready: got ready=0 after 40 cycles want 1"); end
    for (int n = 1; n <= 24; n++) begin
      if (n == 11) begin cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_inc = 8'd128; end
      step();
      cfg_valid = 1'b0;
      e_rx = (n <= 12) ? (n % 4 == 0) : (n % 2 == 0);
      e_tx = (n == 14) || (n == 22);
      n_tests++;
      if ({rx_tick[0], tx_tick[0]} !== {e_rx, e_tx}) begin
        n_fail++;
        $display("FAIL reconfig_n%0d: got rx0,tx0=%b%b want %b%b", n, rx_tick[0], tx_tick[0], e_rx, e_tx);
      end
    end
  endtask

  task automatic test_lock_loss();
    bit ok; int st;
    logic e_rx, e_tx;
    do_reset();
    locked = 1'b1; ch_enable = 3'b001;
    step();
    cfg_write(2'd0, 8'd64);
    wait_ready(40, ok, st);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL loss_ready: got ready=0 after 40 cycles want 1"); end
    repeat (15) step();
    locked = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      n_tests++;
      if ({ready, rx_tick, tx_tick} !== 7'b0) begin
        n_fail++;
        $display("FAIL loss_drop_k%0d: got ready,rx,tx=%b want 0000000", k, {ready, rx_tick, tx_tick});
      end
    end
    locked = 1'b1;
    wait_ready(40, ok, st);
    n_tests++;
    if (!ok || st != c_ls + 1) begin
      n_fail++;
      $display("FAIL loss_relock: got ready after %0d cycles (seen=%b) want %0d", st, ok, c_ls + 1);
    end
    for (int n = 1; n <= 16; n++) begin
      step();
      e_rx = (n % 4 == 0);
      e_tx = (n == 16);
      n_tests++;
      if ({rx_tick[0], tx_tick[0]} !== {e_rx, e_tx}) begin
        n_fail++;
        $display("FAIL loss_relock_n%0d: got rx0,tx0=%b%b want %b%b", n, rx_tick[0], tx_tick[0], e_rx, e_tx);
      end
    end
  endtask

  task automatic test_cfg_out_of_range();
    bit ok; int st; int t, tp;
    logic [2:0] e_rx, e_tx;
    do_reset();
    locked = 1'b1;
    step();
    cfg_write(2'd0, 8'd64);
    cfg_write(2'd1, 8'd96);
    cfg_write(2'd2, 8'd32);
    cfg_write(2'd3, 8'd200);
    ch_enable = 3'b111;
    wait_ready(40, ok, st);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL oor_ready: got ready=0 after 40 cycles want 1"); end
    for (int n = 1; n <= 48; n++) begin
      step();
      t = (3 * n) / 8; tp = (3 * (n - 1)) / 8;
      e_rx = {1'(n % 8 == 0), 1'(t != tp), 1'(n % 4 == 0)};
      e_tx = {1'(n % 32 == 0), 1'(t != tp && t % c_os == 0), 1'(n % 16 == 0)};
      n_tests++;
      if ({rx_tick, tx_tick} !== {e_rx, e_tx}) begin
        n_fail++;
        $display("FAIL oor_n%0d: got rx,tx=%b,%b want %b,%b", n, rx_tick, tx_tick, e_rx, e_tx);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    locked = 1'b1; ch_enable = 3'b111;
    for (int c = 0; c < 2000; c++) begin
      reset = ($urandom_range(0, 699) == 0);
      if (locked && $urandom_range(0, 149) == 0) locked = 1'b0;
      else if (!locked && $urandom_range(0, 2) == 0) locked = 1'b1;
      if ($urandom_range(0, 29) == 0) ch_enable = 3'($urandom_range(0, 7));
      cfg_valid = ($urandom_range(0, 9) == 0);
      cfg_ch    = 2'($urandom_range(0, 3));
      cfg_inc   = 8'($urandom_range(0, 255));
      step();
      n_tests++;
      if ({ready, cfg_ready, rx_tick, tx_tick} !== {m_ready, m_cfg_ready, m_rx, m_tx}) begin
        n_fail++;
        $display("FAIL random_c%0d: got rdy,crdy,rx,tx=%b want %b", c,
                 {ready, cfg_ready, rx_tick, tx_tick}, {m_ready, m_cfg_ready, m_rx, m_tx});
      end
    end
    reset = 1'b0; cfg_valid = 1'b0;
  endtask

  task automatic test_defaults();
    longint t, tp;
    logic e_rx, e_tx;
    d_reset = 1'b1; d_locked = 1'b1; d_en = 2'b11;
    repeat (2) step();
    d_reset = 1'b0;
    for (int k = 1; k <= 1025; k++) begin
      step();
      if (k == 1) begin
        n_tests++;
        if (d_cfg_ready !== 1'b1) begin n_fail++; $display("FAIL def_cfg_ready: got %b want 1", d_cfg_ready); end
      end
      if (k == 1024 || k == 1025) begin
        n_tests++;
        if (d_ready !== 1'(k == 1025)) begin
          n_fail++;
          $display("FAIL def_ready_k%0d: got %b want %b", k, d_ready, k == 1025);
        end
      end
    end
    for (int n = 1; n <= 400; n++) begin
      step();
      t  = (longint'(n) * c_big_def_inc) >> 24;
      tp = (longint'(n - 1) * c_big_def_inc) >> 24;
      e_rx = (t != tp);
      e_tx = e_rx && (t % 16 == 0);
      n_tests++;
      if ({d_rx, d_tx} !== {e_rx, e_rx, e_tx, e_tx}) begin
        n_fail++;
        $display("FAIL def_tick_n%0d: got rx,tx=%b,%b want %b%b,%b%b", n, d_rx, d_tx, e_rx, e_rx, e_tx, e_tx);
      end
    end
  endtask

  initial begin
    reset = 1'b1; locked = 1'b0; ch_enable = '0; cfg_valid = 1'b0; cfg_ch = '0; cfg_inc = '0;
    d_reset = 1'b1; d_locked = 1'b0; d_en = '0; d_cfg_valid = 1'b0; d_cfg_ch = '0; d_cfg_inc = '0;
    test_reset();
    test_lock_qual();
    test_tick_rate();
    test_fractional();
    test_live_reconfig();
    test_lock_loss();
    test_cfg_out_of_range();
    test_random();
    test_defaults();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
